// File: rtl/rgb_status_led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_status_led_ctrl_pkg
//  Description : Shared channel-state encoding, RGB colour constants and the
//                colour decode used by the RGB status LED controller.
//  Revision    : 1.0  initial release
// ============================================================================
package rgb_status_led_ctrl_pkg;

  // Progress of one fault-handling unit; encodings are fixed (IDLE=0..DROPPED=4)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_FAULT   = 3'd2,
    ST_PICKED  = 3'd3,
    ST_DROPPED = 3'd4
  } led_state_e;

  // Colours packed as {R,G,B}
  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  // Colour shown for a channel; blinking colours are lit while phase is 1.
  // Once the run is done every channel blinks green regardless of its state.
  function automatic logic [2:0] led_colour(input led_state_e st,
                                            input logic       phase,
                                            input logic       done);
    logic [2:0] col;
    col = RGB_OFF;
    if (done) begin
      col = phase ? RGB_GREEN : RGB_OFF;
    end else begin
      case (st)
        ST_IDLE:    col = RGB_OFF;
        ST_ARMED:   col = RGB_RED;
        ST_FAULT:   col = RGB_BLUE;
        ST_PICKED:  col = phase ? RGB_BLUE : RGB_OFF;
        ST_DROPPED: col = RGB_GREEN;
        default:    col = RGB_OFF;
      endcase
    end
    return col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_status_led_ctrl_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_status_led_ctrl_blink_timer
//  Description : Free-running blink half-period counter. Counts
//                0..BLINK_HALF-1, flags the wrap cycle and toggles phase on it.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_status_led_ctrl_blink_timer #(
  parameter int BLINK_HALF = 1562500
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic phase_o,
  output logic wrap_o
);

  localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          w_wrap;

  assign w_wrap = (cnt_q == c_LAST);

  // Next counter value and phase: wrap to zero and flip phase on the last count
  always_comb begin
    cnt_d   = w_wrap ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ w_wrap;
  end

  // Counter and phase registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;
  assign wrap_o  = w_wrap;

endmodule
`default_nettype wire

// File: rtl/rgb_status_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_status_led_ctrl
//  Description : Per-unit RGB status indicator. One progress FSM per channel
//                (armed, fault, picked, dropped), a shared blink timer and a
//                sticky run-complete flag that forces an all-green blink.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_status_led_ctrl
  import rgb_status_led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 3,
  parameter int BLINK_HALF = 1562500,
  parameter int SEL_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk_3125KHz,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] unit_active,
  input  logic [SEL_W-1:0]    evt_unit,
  input  logic                fault_detect,
  input  logic                block_picked,
  input  logic                object_drop,
  input  logic                run_complete,
  output logic [NUM_LEDS-1:0] led_r,
  output logic [NUM_LEDS-1:0] led_g,
  output logic [NUM_LEDS-1:0] led_b
);

  logic w_phase;
  logic w_wrap;
  logic w_phase_next;
  logic done_q, done_d;

  rgb_status_led_ctrl_blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk_i  (clk_3125KHz),
    .rst_ni (rst_n),
    .phase_o(w_phase),
    .wrap_o (w_wrap)
  );

  // Phase the LED registers will be displayed with after this edge
  assign w_phase_next = w_phase ^ w_wrap;

  // Sticky run-complete flag
  always_comb begin
    done_d = done_q | run_complete;
  end

  // Done flag register
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    localparam logic [SEL_W-1:0] c_IDX = SEL_W'(gi);

    led_state_e state_q, state_d;
    logic [2:0] rgb_q, rgb_d;
    logic       w_hit;

    // Out-of-range indices never match any channel, so they are ignored
    assign w_hit = (evt_unit == c_IDX);

    // Next state and next colour; abort (unit inactive) beats any event
    always_comb begin
      state_d = state_q;
      if (!done_q) begin
        case (state_q)
          ST_IDLE:    if (unit_active[gi])             state_d = ST_ARMED;
          ST_ARMED:   if (!unit_active[gi])            state_d = ST_IDLE;
                      else if (fault_detect && w_hit)  state_d = ST_FAULT;
          ST_FAULT:   if (!unit_active[gi])            state_d = ST_IDLE;
                      else if (block_picked && w_hit)  state_d = ST_PICKED;
          ST_PICKED:  if (!unit_active[gi])            state_d = ST_IDLE;
                      else if (object_drop && w_hit)   state_d = ST_DROPPED;
          ST_DROPPED: state_d = ST_DROPPED;
          default:    state_d = ST_IDLE;
        endcase
      end
      rgb_d = led_colour(state_d, w_phase_next, done_d);
    end

    // Channel state and registered colour output
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        rgb_q   <= RGB_OFF;
      end else begin
        state_q <= state_d;
        rgb_q   <= rgb_d;
      end
    end

    assign led_r[gi] = rgb_q[2];
    assign led_g[gi] = rgb_q[1];
    assign led_b[gi] = rgb_q[0];
  end : g_chan

endmodule
`default_nettype wire

// File: tb/tb_rgb_status_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_status_led_ctrl
//  Description : Scoreboard bench for rgb_status_led_ctrl. A stimulus process
//                drives inputs and pushes the reference model's expected LEDs;
//                a monitor pops and compares on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_status_led_ctrl;

  localparam int NL = 3;
  localparam int BH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] unit_active;
  logic [1:0]    evt_unit;
  logic          fault_detect, block_picked, object_drop, run_complete;
  logic [NL-1:0] led_r, led_g, led_b;

  always #5 clk = ~clk;

  rgb_status_led_ctrl #(
    .NUM_LEDS  (NL),
    .BLINK_HALF(BH)
  ) dut (
    .clk_3125KHz (clk),
    .rst_n       (rst_n),
    .unit_active (unit_active),
    .evt_unit    (evt_unit),
    .fault_detect(fault_detect),
    .block_picked(block_picked),
    .object_drop (object_drop),
    .run_complete(run_complete),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b)
  );

  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;
  logic [8:0] mon_got;
  bit         rst_req;

  // Reference model: progress stage per unit (0 idle, 1 armed, 2 fault,
  // 3 picked, 4 dropped), done flag, clock edges since reset release.
  int m_st[NL];
  bit m_done;
  int m_cyc;

  function automatic logic [2:0] colour(input int st, input bit ph, input bit dn);
    if (dn) return ph ? 3'b010 : 3'b000;
    case (st)
      1:       return 3'b100;
      2:       return 3'b001;
      3:       return ph ? 3'b001 : 3'b000;
      4:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_st[c]) m_st[c] = 0;
    m_done = 1'b0;
    m_cyc  = 0;
  endtask

  // One clock edge of the reference model; returns expected {led_r,led_g,led_b}
  task automatic model_edge(input logic [NL-1:0] ua, input int eu, input bit f,
                            input bit b, input bit o, input bit r,
                            output logic [8:0] e);
    bit ev[3];
    bit ph;
    logic [2:0] col;
    e = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev[0] = f; ev[1] = b; ev[2] = o;
    m_cyc++;
    if (!m_done) begin
      for (int c = 0; c < NL; c++) begin
        if (m_st[c] == 0) begin
          if (ua[c]) m_st[c] = 1;
        end else if (m_st[c] >= 1 && m_st[c] <= 3) begin
          if (!ua[c]) m_st[c] = 0;
          else if (eu == c && ev[m_st[c]-1]) m_st[c] = m_st[c] + 1;
        end
      end
    end
    if (r) m_done = 1'b1;
    ph = ((m_cyc / BH) % 2) == 1;
    for (int c = 0; c < NL; c++) begin
      col = colour(m_st[c], ph, m_done);
      e[6+c] = col[2];
      e[3+c] = col[1];
      e[c]   = col[0];
    end
  endtask

  task automatic step(input logic [NL-1:0] ua, input int eu, input bit f,
                      input bit b, input bit o, input bit r);
    logic [8:0] e;
    @(negedge clk);
    rst_n        = rst_req;
    unit_active  = ua;
    evt_unit     = 2'(eu);
    fault_detect = f;
    block_picked = b;
    object_drop  = o;
    run_complete = r;
    @(posedge clk);
    model_edge(ua, eu, f, b, o, r, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [NL-1:0] ua, input int n);
    for (int k = 0; k < n; k++) step(ua, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in the middle of a cycle must clear outputs at once
  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_req = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #1;
    total++;
    if ({led_r, led_g, led_b} !== 9'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", {led_r, led_g, led_b}, 9'b0);
    end
  endtask

  // Monitor: one output word per clock, compared against the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {led_r, led_g, led_b};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL leds t=%0t got rgb=%b want rgb=%b", $time, mon_got, mon_exp);
      end
    end
  end

  initial begin
    logic [NL-1:0] ua;
    rst_req      = 1'b0;
    rst_n        = 1'b0;
    unit_active  = '0;
    evt_unit     = '0;
    fault_detect = 1'b0;
    block_picked = 1'b0;
    object_drop  = 1'b0;
    run_complete = 1'b0;
    model_reset();

    // Reset held with inputs toggling, then quiet after release
    for (int k = 0; k < 6; k++)
      step(3'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    rst_req = 1'b1;
    idle(3'b000, 10);

    // Unit 0 full progression including PICKED blink
    step(3'b001, 0, 0, 0, 0, 0);
    idle(3'b001, 2);
    step(3'b001, 0, 1, 0, 0, 0);
    idle(3'b001, 3);
    step(3'b001, 0, 0, 1, 0, 0);
    idle(3'b001, 12);
    step(3'b001, 0, 0, 0, 1, 0);
    idle(3'b001, 3);

    // Unit 1 drop before fault is ignored, then abort
    step(3'b011, 0, 0, 0, 0, 0);
    step(3'b011, 1, 0, 0, 1, 0);
    idle(3'b011, 2);
    step(3'b001, 0, 0, 0, 0, 0);
    idle(3'b001, 2);

    // Out-of-range index ignored; simultaneous pulses only act legally
    idle(3'b111, 2);
    step(3'b111, 3, 1, 1, 1, 0);
    idle(3'b111, 2);
    step(3'b111, 2, 1, 1, 0, 0);
    idle(3'b111, 2);
    step(3'b111, 1, 1, 0, 0, 0);
    step(3'b111, 1, 0, 1, 0, 0);
    idle(3'b111, 3);

    // Run complete with mixed states; later events and aborts ignored
    step(3'b111, 0, 0, 0, 0, 1);
    idle(3'b111, 12);
    step(3'b000, 1, 0, 0, 1, 0);
    step(3'b000, 2, 0, 1, 0, 0);
    idle(3'b000, 10);
    async_reset_check();
    idle(3'b000, 3);
    rst_req = 1'b1;
    idle(3'b000, 14);

    // Randomised traffic against the model
    ua = '0;
    for (int k = 0; k < 450; k++) begin
      for (int c = 0; c < NL; c++)
        if ($urandom_range(0, 15) == 0) ua[c] = ~ua[c];
      step(ua, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 299) == 0);
    end
    async_reset_check();
    idle(3'b000, 2);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
